// File: rtl/ex_muldiv_unit_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: widths, funct3 codes,
// FSM state encoding and small operand helpers.
package ex_muldiv_unit_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = $clog2(XLEN);

  localparam logic [2:0] FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
  localparam logic [2:0] FUNCT3_DIV    = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
  localparam logic [2:0] FUNCT3_REM    = 3'b110;
  localparam logic [2:0] FUNCT3_REMU   = 3'b111;

  localparam logic [XLEN-1:0] SignedMin = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMul  = 2'd1,
    StDiv  = 2'd2,
    StDone = 2'd3
  } muldiv_state_e;

  typedef struct packed {
    logic rs1_signed;
    logic rs2_signed;
  } sign_cfg_t;

  // Which operands are interpreted as two's complement for a given funct3.
  function automatic sign_cfg_t sign_cfg(input logic [2:0] funct3);
    sign_cfg_t cfg;
    cfg = '0;
    case (funct3)
      FUNCT3_MUL, FUNCT3_MULH, FUNCT3_DIV, FUNCT3_REM: cfg = '{rs1_signed: 1'b1, rs2_signed: 1'b1};
      FUNCT3_MULHSU:                                   cfg = '{rs1_signed: 1'b1, rs2_signed: 1'b0};
      FUNCT3_MULHU, FUNCT3_DIVU, FUNCT3_REMU:          cfg = '{rs1_signed: 1'b0, rs2_signed: 1'b0};
      default:                                         cfg = '0;
    endcase
    return cfg;
  endfunction

  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] x, input logic is_signed);
    return (is_signed && x[XLEN-1]) ? -x : x;
  endfunction

  // MUL returns the low half; all MULH* forms return the high half.
  function automatic logic [XLEN-1:0] mul_select(input logic [1:0]        f3_lo,
                                                 input logic [2*XLEN-1:0] prod);
    return (f3_lo == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// ID/EX -> muldiv request and muldiv -> EX/MEM result bundle.
interface ex_muldiv_unit_if;
  import ex_muldiv_unit_pkg::*;

  logic            start_i;
  logic            flush_i;
  logic            hold_i;
  logic [2:0]      funct3_i;
  logic [XLEN-1:0] rs1_value_i;
  logic [XLEN-1:0] rs2_value_i;
  logic [4:0]      rd_i;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;
  logic [4:0]      rd_o;

  modport master (
    output start_i, flush_i, hold_i, funct3_i, rs1_value_i, rs2_value_i, rd_i,
    input  busy_o, done_o, result_o, rd_o
  );

  modport slave (
    input  start_i, flush_i, hold_i, funct3_i, rs1_value_i, rs2_value_i, rd_i,
    output busy_o, done_o, result_o, rd_o
  );

endinterface

// File: rtl/ex_muldiv_unit_divider_core.sv
// Restoring unsigned divider datapath: one shift/subtract step per enabled cycle.
// The *_nxt_o outputs show the values produced by the current step so the caller
// can sign-fix the final result in the same cycle as the last step.
module ex_muldiv_unit_divider_core
  import ex_muldiv_unit_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clear_i,
  input  logic            load_i,
  input  logic            step_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quo_nxt_o,
  output logic [XLEN-1:0] rem_nxt_o
);

  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;
  logic [XLEN-1:0] rem_step;
  logic [XLEN-1:0] quo_step;

  // One restoring step; diff MSB set means the trial subtraction went negative.
  always_comb begin
    shifted  = {rem_q, quo_q[XLEN-1]};
    diff     = shifted - {1'b0, dvs_q};
    rem_step = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
    quo_step = {quo_q[XLEN-2:0], ~diff[XLEN]};
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    if (clear_i) begin
      rem_d = '0;
      quo_d = '0;
      dvs_d = '0;
    end else if (load_i) begin
      rem_d = '0;
      quo_d = dividend_i;
      dvs_d = divisor_i;
    end else if (step_i) begin
      rem_d = rem_step;
      quo_d = quo_step;
    end
  end

  assign quo_nxt_o = quo_step;
  assign rem_nxt_o = rem_step;

  // Datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage. Operates on magnitudes
// and sign-fixes at the end. Define MULDIV_FAST_MUL_EN to replace the shift-add
// multiplier with a single-cycle product (no MUL state); divide is unchanged.
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
(
  input logic             clk_i,
  input logic             rst_i,
  ex_muldiv_unit_if.slave bus
);

  muldiv_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [4:0]       rd_q, rd_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic             done_q, done_d;

  sign_cfg_t        sc;
  logic             rs1_neg, rs2_neg;
  logic [XLEN-1:0]  rs1_abs, rs2_abs;
  logic             div_ovf;
  logic             div_load, div_step, div_clear;
  logic [XLEN-1:0]  quo_nxt, rem_nxt;
  logic [XLEN-1:0]  quo_fix, rem_fix;
  logic [XLEN-1:0]  div_sel;
  logic [XLEN-1:0]  fin_result;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] prod_fast;
`else
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] prod_step;
  logic [2*XLEN-1:0] prod_final;
`endif

  assign sc      = sign_cfg(bus.funct3_i);
  assign rs1_neg = sc.rs1_signed & bus.rs1_value_i[XLEN-1];
  assign rs2_neg = sc.rs2_signed & bus.rs2_value_i[XLEN-1];
  assign rs1_abs = abs_val(bus.rs1_value_i, sc.rs1_signed);
  assign rs2_abs = abs_val(bus.rs2_value_i, sc.rs2_signed);
  assign div_ovf = sc.rs1_signed && (bus.rs1_value_i == SignedMin) && (bus.rs2_value_i == '1);

  ex_muldiv_unit_divider_core u_divider_core (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clear_i    (div_clear),
    .load_i     (div_load),
    .step_i     (div_step),
    .dividend_i (rs1_abs),
    .divisor_i  (rs2_abs),
    .quo_nxt_o  (quo_nxt),
    .rem_nxt_o  (rem_nxt)
  );

  // Final-step datapath: multiplier step, sign fixes and result selection.
  always_comb begin
    quo_fix = neg_res_q ? -quo_nxt : quo_nxt;
    rem_fix = neg_rem_q ? -rem_nxt : rem_nxt;
    div_sel = op_q[1] ? rem_fix : quo_fix;
`ifdef MULDIV_FAST_MUL_EN
    prod_fast  = {{XLEN{rs1_neg}}, bus.rs1_value_i} * {{XLEN{rs2_neg}}, bus.rs2_value_i};
    fin_result = div_sel;
`else
    mul_sum    = {1'b0, prod_q[2*XLEN-1:XLEN]} +
                 (prod_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
    prod_step  = {mul_sum, prod_q[XLEN-1:1]};
    prod_final = neg_res_q ? -prod_step : prod_step;
    fin_result = op_q[2] ? div_sel : mul_select(op_q[1:0], prod_final);
`endif
  end

  // FSM next-state; flush overrides every transition.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    rd_d      = rd_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    done_d    = done_q;
`ifndef MULDIV_FAST_MUL_EN
    mcand_d   = mcand_q;
    prod_d    = prod_q;
`endif
    div_load  = 1'b0;
    div_step  = 1'b0;
    div_clear = 1'b0;

    unique case (state_q)
      StIdle: begin
        done_d = 1'b0;
        if (bus.start_i) begin
          op_d  = bus.funct3_i;
          rd_d  = bus.rd_i;
          cnt_d = CNT_W'(XLEN - 1);
          if (!bus.funct3_i[2]) begin
`ifdef MULDIV_FAST_MUL_EN
            result_d = mul_select(bus.funct3_i[1:0], prod_fast);
            done_d   = 1'b1;
            state_d  = StDone;
`else
            mcand_d   = rs1_abs;
            prod_d    = {{XLEN{1'b0}}, rs2_abs};
            neg_res_d = rs1_neg ^ rs2_neg;
            state_d   = StMul;
`endif
          end else if (bus.rs2_value_i == '0) begin
            // Divide by zero: quotient all-ones, remainder is the dividend.
            result_d = bus.funct3_i[1] ? bus.rs1_value_i : '1;
            done_d   = 1'b1;
            state_d  = StDone;
          end else if (div_ovf) begin
            result_d = bus.funct3_i[1] ? '0 : SignedMin;
            done_d   = 1'b1;
            state_d  = StDone;
          end else begin
            div_load  = 1'b1;
            neg_res_d = rs1_neg ^ rs2_neg;
            neg_rem_d = rs1_neg;
            state_d   = StDiv;
          end
        end
      end
`ifndef MULDIV_FAST_MUL_EN
      StMul: begin
        prod_d = prod_step;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          result_d = fin_result;
          done_d   = 1'b1;
          state_d  = StDone;
        end
      end
`endif
      StDiv: begin
        div_step = 1'b1;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          result_d = fin_result;
          done_d   = 1'b1;
          state_d  = StDone;
        end
      end
      StDone: begin
        // start_i here still belongs to the retiring instruction.
        if (!bus.hold_i) begin
          done_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (bus.flush_i) begin
      state_d   = StIdle;
      cnt_d     = '0;
      op_d      = '0;
      rd_d      = '0;
      neg_res_d = 1'b0;
      neg_rem_d = 1'b0;
      result_d  = '0;
      done_d    = 1'b0;
`ifndef MULDIV_FAST_MUL_EN
      mcand_d   = '0;
      prod_d    = '0;
`endif
      div_clear = 1'b1;
    end
  end

  // State, control and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      done_q    <= 1'b0;
`ifndef MULDIV_FAST_MUL_EN
      mcand_q   <= '0;
      prod_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      done_q    <= done_d;
`ifndef MULDIV_FAST_MUL_EN
      mcand_q   <= mcand_d;
      prod_q    <= prod_d;
`endif
    end
  end

  assign bus.busy_o   = bus.start_i && (state_q != StDone);
  assign bus.done_o   = done_q;
  assign bus.result_o = result_q;
  assign bus.rd_o     = rd_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: directed and random RV32M ops compared every cycle
// against an arithmetic reference model. Honours MULDIV_FAST_MUL_EN for latency.
module tb_ex_muldiv_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ex_muldiv_unit_if bus ();

  ex_muldiv_unit dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Driver-supplied literal expectation for the op being started.
  logic        lit_en  = 1'b0;
  logic [31:0] lit_val = '0;

  // Model state, written only by the model process.
  int          m_phase = 0; // 0 idle, 1 computing, 2 result presented
  int          m_cnt   = 0;
  logic        m_done  = 1'b0;
  logic        m_zero  = 1'b1;
  logic [31:0] m_res   = '0;
  logic [4:0]  m_rd    = '0;
  logic        m_lit_en = 1'b0;
  logic [31:0] m_lit   = '0;

  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, b);
    longint      sa, sb, ub, p;
    logic [63:0] up;
    int          ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    ia = $signed(a);
    ib = $signed(b);
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, b);
    if (!f[2]) begin
`ifdef MULDIV_FAST_MUL_EN
      return 1;
`else
      return 33;
`endif
    end
    if (b == 0) return 1;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // Reference model: advances on each rising edge from the applied inputs.
  initial forever begin
    @(posedge clk);
    if (rst || bus.flush_i) begin
      m_phase = 0;
      m_done  = 1'b0;
      m_rd    = '0;
      m_zero  = 1'b1;
    end else begin
      case (m_phase)
        0: if (bus.start_i) begin
          m_res    = ref_result(bus.funct3_i, bus.rs1_value_i, bus.rs2_value_i);
          m_rd     = bus.rd_i;
          m_lit_en = lit_en;
          m_lit    = lit_val;
          m_cnt    = ref_latency(bus.funct3_i, bus.rs1_value_i, bus.rs2_value_i) - 1;
          if (m_cnt == 0) begin
            m_phase = 2;
            m_done  = 1'b1;
            m_zero  = 1'b0;
          end else begin
            m_phase = 1;
          end
        end
        1: begin
          m_cnt--;
          if (m_cnt == 0) begin
            m_phase = 2;
            m_done  = 1'b1;
            m_zero  = 1'b0;
          end
        end
        default: if (!bus.hold_i) begin
          m_phase = 0;
          m_done  = 1'b0;
        end
      endcase
    end
  end

  // Compare process: every falling edge, DUT outputs against the model.
  initial forever begin
    @(negedge clk);
    chk("busy_o", 32'(bus.busy_o), 32'(bus.start_i && (m_phase != 2)));
    chk("done_o", 32'(bus.done_o), 32'(m_done));
    chk("rd_o", 32'(bus.rd_o), 32'(m_rd));
    if (m_done) chk("result_o", bus.result_o, m_res);
    if (m_done && m_lit_en) chk("result_literal", bus.result_o, m_lit);
    if (m_zero) chk("result_cleared", bus.result_o, 32'h0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one op with start_i held until done_o, then holds DONE for nhold cycles.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] r, input int nhold, input logic le,
                       input logic [31:0] lv);
    int n;
    n               = 0;
    lit_en          = le;
    lit_val         = lv;
    bus.start_i     = 1'b1;
    bus.funct3_i    = f;
    bus.rs1_value_i = a;
    bus.rs2_value_i = b;
    bus.rd_i        = r;
    bus.hold_i      = 1'b0;
    do begin
      step();
      n++;
    end while (!bus.done_o && n < 60);
    bus.hold_i = (nhold > 0);
    for (int i = 0; i < nhold; i++) step();
    bus.hold_i = 1'b0;
    step();
    bus.start_i = 1'b0;
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] specials [6];
    specials = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};
    if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 5)];
    if ($urandom_range(0, 1) == 0) return 32'($signed(16'($urandom)));
    return $urandom;
  endfunction

  initial begin
    bus.start_i     = 1'b0;
    bus.flush_i     = 1'b0;
    bus.hold_i      = 1'b0;
    bus.funct3_i    = '0;
    bus.rs1_value_i = '0;
    bus.rs2_value_i = '0;
    bus.rd_i        = '0;
    rst             = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Directed ops with hand-computed results.
    do_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd1, 0, 1'b1, 32'hFFFF_FFEB);
    do_op(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd2, 0, 1'b1, 32'h4000_0000);
    do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 0, 1'b1, 32'hFFFF_FFFE);
    do_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 0, 1'b1, 32'hFFFF_FFFF);
    do_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd5, 0, 1'b1, 32'hFFFF_FFFD);
    do_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6, 0, 1'b1, 32'hFFFF_FFFF);
    do_op(3'b101, 32'd100, 32'd7, 5'd7, 0, 1'b1, 32'd14);
    do_op(3'b111, 32'd100, 32'd7, 5'd8, 3, 1'b1, 32'd2);
    do_op(3'b100, 32'd5, 32'd0, 5'd9, 0, 1'b1, 32'hFFFF_FFFF);
    do_op(3'b110, 32'd5, 32'd0, 5'd10, 0, 1'b1, 32'd5);
    do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0, 1'b1, 32'h8000_0000);
    do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 2, 1'b1, 32'h0);
    do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 0, 1'b1, 32'h8000_0000);

    // Flush in the middle of a divide, then a clean divide.
    lit_en          = 1'b0;
    bus.start_i     = 1'b1;
    bus.funct3_i    = 3'b100;
    bus.rs1_value_i = 32'd1000;
    bus.rs2_value_i = 32'd7;
    bus.rd_i        = 5'd14;
    repeat (10) step();
    bus.flush_i = 1'b1;
    step();
    bus.flush_i = 1'b0;
    bus.start_i = 1'b0;
    repeat (2) step();
    do_op(3'b101, 32'd1000, 32'd7, 5'd15, 0, 1'b1, 32'd142);

    // Reset in the middle of a multiply.
    lit_en          = 1'b0;
    bus.start_i     = 1'b1;
    bus.funct3_i    = 3'b000;
    bus.rs1_value_i = 32'd12345;
    bus.rs2_value_i = 32'd678;
    bus.rd_i        = 5'd16;
    repeat (5) step();
    rst         = 1'b1;
    bus.start_i = 1'b0;
    step();
    rst = 1'b0;
    repeat (2) step();
    do_op(3'b000, 32'd12345, 32'd678, 5'd17, 1, 1'b1, 32'd8369910);

    // Random ops against the model.
    for (int k = 0; k < 200; k++) begin
      do_op(3'($urandom_range(0, 7)), rand_operand(), rand_operand(), 5'($urandom),
            int'($urandom_range(0, 2)), 1'b0, 32'h0);
    end

    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
